// File: rtl/booth_arb_pkg.sv
// Shared types and helpers for the booth multiplier arbiter.
package booth_arb_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_e;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick
    import booth_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             found
);

    int idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        // k = N_REQ lands back on ptr itself, so the last winner is checked last
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one serial-load booth multiplier among N_REQ clients,
// with a watchdog that turns a hung datapath into an error response.
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   op_a,
    input  logic [N_REQ*WIDTH-1:0]   op_b,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [id_w(N_REQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_err,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_data,
    input  logic                     mult_done,
    input  logic [2*WIDTH-1:0]       mult_result
);

    localparam int ID_W  = id_w(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 err_q, err_d;

    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 mult_start_q, mult_start_d;
    logic [WIDTH-1:0]     mult_data_q, mult_data_d;

    logic [ID_W-1:0]      win;
    logic                 found;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .found (found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (found) begin
                id_d    = win;
                a_d     = op_a[int'(win)*WIDTH +: WIDTH];
                b_d     = op_b[int'(win)*WIDTH +: WIDTH];
                state_d = LOAD_A;
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done has priority over a simultaneous watchdog expiry
                if (mult_done) begin
                    res_d   = mult_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the flops line up with the state.
        gnt_d = '0;
        if (state_d == LOAD_A) gnt_d[id_d] = 1'b1;
        busy_d       = (state_d != IDLE);
        mult_start_d = (state_d == LOAD_A);
        mult_data_d  = (state_d == LOAD_A) ? a_d :
                       (state_d == LOAD_B) ? b_d : '0;
        rsp_valid_d  = (state_d == RESP);
        rsp_id_d     = (state_d == RESP) ? id_d  : '0;
        rsp_result_d = (state_d == RESP) ? res_d : '0;
        rsp_err_d    = (state_d == RESP) ? err_d : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            mult_start_q <= 1'b0;
            mult_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            err_q        <= err_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            mult_start_q <= mult_start_d;
            mult_data_q  <= mult_data_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign mult_start = mult_start_q;
    assign mult_data  = mult_data_q;

endmodule
